// File: rtl/xpb_pkg.sv
// xpb_pkg: shared defaults and FSM state encoding for the xpb table generator.
package xpb_pkg;
    localparam int XPB_DATA_W = 1024;
    localparam int XPB_IDX_W  = 5;
    localparam int XPB_LIMB_W = 64;
    localparam int XPB_NLIMB  = XPB_DATA_W / XPB_LIMB_W;
    typedef enum logic [2:0] {IDLE, WR0, ADD, WRITE, FIN} state_t;
endpackage

// File: rtl/xpb_limb_addsub.sv
// xpb_limb_addsub: one limb of acc+B (with carry) and of that sum minus M (with borrow).
module xpb_limb_addsub
    import xpb_pkg::*;
#(
    parameter int W = XPB_LIMB_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    input  logic         ci,
    input  logic         bi,
    output logic [W-1:0] s,
    output logic [W-1:0] d,
    output logic         co,
    output logic         bo
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign {bo, d} = {1'b0, s} - {1'b0, m} - {{W{1'b0}}, bi};
endmodule

// File: rtl/xpb_table_gen.sv
// xpb_table_gen: writes entry[j] = (j*B) mod M for every table index, one limb per cycle.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int DATA_W = XPB_DATA_W,
    parameter int IDX_W  = XPB_IDX_W,
    parameter int LIMB_W = XPB_LIMB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] modulus,
    input  logic [DATA_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam int NLIMB = DATA_W / LIMB_W;
    localparam int LW    = NLIMB > 1 ? $clog2(NLIMB) : 1;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   acc_sh, b_sh, m_sh, sum_sh, diff_sh, res;
    logic [IDX_W-1:0]    idx;
    logic [LW-1:0]       limb;
    logic                c, bw, co, bo, last_limb;
    logic [LIMB_W-1:0]   s, d;

    xpb_limb_addsub #(.W(LIMB_W)) u_addsub (
        .a  (acc_sh[LIMB_W-1:0]),
        .b  (b_sh[LIMB_W-1:0]),
        .m  (m_sh[LIMB_W-1:0]),
        .ci (c),
        .bi (bw),
        .s  (s),
        .d  (d),
        .co (co),
        .bo (bo)
    );

    assign last_limb = limb == LW'(NLIMB - 1);
    // acc + B < 2M, so a carry out of the sum or no borrow from the subtract means reduce
    assign res = (c | ~bw) ? diff_sh : sum_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (start ? WR0 : IDLE) :
                   state == WR0   ? ADD :
                   state == ADD   ? (last_limb ? WRITE : ADD) :
                   state == WRITE ? (&idx ? FIN : ADD) : IDLE;
        busy     = state != IDLE;
        done     = state == FIN;
        wr_en    = state == WR0 || state == WRITE;
        wr_addr  = state == WRITE ? idx : '0;
        wr_data  = state == WRITE ? res : '0;
    end

    // B and M rotate so they are back in place after NLIMB limbs; sum/diff fill from the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sh  <= '0;
            b_sh    <= '0;
            m_sh    <= '0;
            sum_sh  <= '0;
            diff_sh <= '0;
            idx     <= '0;
            limb    <= '0;
            c       <= 1'b0;
            bw      <= 1'b0;
        end else if (state == IDLE && start) begin
            acc_sh <= '0;
            b_sh   <= base;
            m_sh   <= modulus;
        end else if (state == WR0) begin
            idx  <= IDX_W'(1);
            limb <= '0;
            c    <= 1'b0;
            bw   <= 1'b0;
        end else if (state == ADD) begin
            acc_sh  <= acc_sh >> LIMB_W;
            b_sh    <= (b_sh >> LIMB_W) | (b_sh << (DATA_W - LIMB_W));
            m_sh    <= (m_sh >> LIMB_W) | (m_sh << (DATA_W - LIMB_W));
            sum_sh  <= (sum_sh >> LIMB_W) | (DATA_W'(s) << (DATA_W - LIMB_W));
            diff_sh <= (diff_sh >> LIMB_W) | (DATA_W'(d) << (DATA_W - LIMB_W));
            c       <= co;
            bw      <= bo;
            limb    <= last_limb ? '0 : limb + LW'(1);
        end else if (state == WRITE) begin
            acc_sh <= res;
            idx    <= idx + IDX_W'(1);
            c      <= 1'b0;
            bw     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xpb_table_gen.sv
// tb_xpb_table_gen: scoreboard bench; expected entries come from (j*B) % M in plain integer arithmetic.
module tb_xpb_table_gen;
    localparam int DW  = 16;
    localparam int LW  = 4;
    localparam int IW  = 3;
    localparam int N   = 1 << IW;
    localparam int LAT = 1 + (N - 1) * (DW / LW + 1) + 1;

    typedef struct {
        logic [IW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk, rst_n, start, busy, done, wr_en;
    logic [DW-1:0] modulus, base, wr_data;
    logic [IW-1:0] wr_addr;
    exp_t          exp_q[$];
    int            checks = 0, failures = 0, wr_cnt = 0;

    xpb_table_gen #(.DATA_W(DW), .IDX_W(IW), .LIMB_W(LW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .modulus (modulus),
        .base    (base),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", n, act, req);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] m, input logic [DW-1:0] b, input int upto);
        for (int j = 0; j < upto; j++)
            exp_q.push_back('{addr: IW'(j), data: DW'((longint'(j) * longint'(b)) % longint'(m))});
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=0x%0h data=0x%0h expected=none", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic run_table(input logic [DW-1:0] m, input logic [DW-1:0] b, input bit poke);
        int cnt, w0;
        push_exp(m, b, N);
        w0 = wr_cnt;
        start = 1'b1;
        modulus = m;
        base = b;
        @(posedge clk); #1;
        start = 1'b0;
        modulus = DW'($urandom);
        base = DW'($urandom);
        cnt = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!done && cnt < 4 * LAT) begin
            if (poke) start = (cnt % 7 == 3);
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, LAT);
        start = poke;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("wr_count", wr_cnt - w0, N);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic reset_mid(input logic [DW-1:0] m, input logic [DW-1:0] b);
        int cnt;
        push_exp(m, b, 5);
        start = 1'b1;
        modulus = m;
        base = b;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 1;
        // entry 5 occupies cycles 22..26; cycle 25 is its limb 3
        while (cnt < 25) begin
            @(posedge clk); #1;
            cnt++;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] m, b;
        rst_n = 1'b0;
        start = 1'b0;
        modulus = '0;
        base = '0;
        #3;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_table(16'h00FB, 16'h0064, 1'b0);
        run_table(16'h00FB, 16'h0000, 1'b0);
        run_table(16'h00FB, 16'h00FA, 1'b0);
        run_table(16'hFFF1, 16'hFFF0, 1'b0);
        reset_mid(16'h00FB, 16'h0064);
        run_table(16'h00FB, 16'h0064, 1'b0);
        run_table(16'h00FB, 16'h0064, 1'b1);
        repeat (8) begin
            m = DW'($urandom) | DW'(1);
            b = DW'($urandom % 32'(m));
            run_table(m, b, 1'($urandom_range(0, 1)));
        end
        run_table(16'hFFFF, 16'hFFFE, 1'b0);
        run_table(16'h0001, 16'h0000, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
